// File: rtl/param_seq_shifter_if.sv
// Start/busy/done handshake bundle for the multi-cycle shifter.
// Carries the operand request and the registered result.
interface param_seq_shifter_if #(
  parameter int WIDTH = 32,
  parameter int SW    = $clog2(WIDTH)
);
  logic             start;
  logic [1:0]       mode;
  logic [SW-1:0]    shamt;
  logic [WIDTH-1:0] in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] out;

  modport master (
    output start, mode, shamt, in,
    input  busy, done, out
  );

  modport slave (
    input  start, mode, shamt, in,
    output busy, done, out
  );
endinterface

// File: rtl/param_seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROL shifter, up to STEP bits per clock.
// One request in flight; result registered and held until next done.
module param_seq_shifter #(
  parameter  int WIDTH = 32,
  parameter  int STEP  = 1,
  localparam int SW    = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  param_seq_shifter_if.slave bus
);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;
  localparam logic [1:0] M_ROL = 2'b11;

  localparam logic [SW-1:0] STEPV = SW'(STEP);

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [SW-1:0]    rem;
  logic [1:0]       md;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] out_q;

  logic [SW-1:0]    s;
  logic [SW:0]      rs;
  logic [WIDTH-1:0] nxt;

  // Partial final step shifts only the bits that remain.
  always_comb begin
    s   = (rem < STEPV) ? rem : STEPV;
    rs  = (SW+1)'(WIDTH) - {1'b0, s};
    nxt = acc;
    unique case (md)
      M_SLL: nxt = acc << s;
      M_SRL: nxt = acc >> s;
      M_SRA: nxt = $signed(acc) >>> s;
      M_ROL: nxt = (acc << s) | (acc >> rs);
      default: nxt = acc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      md     <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            acc    <= bus.in;
            rem    <= bus.shamt;
            md     <= bus.mode;
            busy_q <= 1'b1;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          if (rem != '0) begin
            acc <= nxt;
            rem <= rem - s;
          end else begin
            out_q  <= acc;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.out  = out_q;

endmodule

// File: tb/tb_param_seq_shifter.sv
// Scoreboard bench for param_seq_shifter, STEP=1 and STEP=4 instances.
// Expected results come from a bit-serial reference model.
module tb_param_seq_shifter;

  typedef struct {
    logic [31:0] v;
    int          lat;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;
  exp_t sb[$];

  param_seq_shifter_if #(.WIDTH(32)) b1 ();
  param_seq_shifter_if #(.WIDTH(32)) b4 ();

  param_seq_shifter #(.WIDTH(32), .STEP(1)) d1 (
    .clk(clk), .rst_n(rst_n), .bus(b1.slave)
  );

  param_seq_shifter #(.WIDTH(32), .STEP(4)) d4 (
    .clk(clk), .rst_n(rst_n), .bus(b4.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input logic [1:0] m, input int sh, input logic [31:0] x
  );
    logic [31:0] v;
    v = x;
    for (int i = 0; i < sh; i++) begin
      case (m)
        2'b00: v = {v[30:0], 1'b0};
        2'b01: v = {1'b0, v[31:1]};
        2'b10: v = {v[31], v[31:1]};
        default: v = {v[30:0], v[31]};
      endcase
    end
    return v;
  endfunction

  function automatic int lat_of(input int sh, input int st);
    return (sh + st - 1) / st + 1;
  endfunction

  function automatic logic get_done(input int sel);
    return sel == 4 ? b4.done : b1.done;
  endfunction

  function automatic logic get_busy(input int sel);
    return sel == 4 ? b4.busy : b1.busy;
  endfunction

  function automatic logic [31:0] get_out(input int sel);
    return sel == 4 ? b4.out : b1.out;
  endfunction

  task automatic drive(
    input int sel, input logic st, input logic [1:0] m,
    input int sh, input logic [31:0] x
  );
    if (sel == 4) begin
      b4.start = st; b4.mode = m;
      b4.shamt = 5'(sh); b4.in = x;
    end else begin
      b1.start = st; b1.mode = m;
      b1.shamt = 5'(sh); b1.in = x;
    end
  endtask

  // Drive at current time, accept on next edge, push expectation.
  task automatic issue(
    input int sel, input logic [1:0] m,
    input int sh, input logic [31:0] x
  );
    exp_t e;
    drive(sel, 1'b1, m, sh, x);
    e.v   = model(m, sh, x);
    e.lat = lat_of(sh, sel == 4 ? 4 : 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive(sel, 1'b0, 2'b00, 0, 32'h0);
  endtask

  // Returns #1 after the edge on which done rose.
  task automatic wait_done(input int sel, input string nm);
    exp_t e;
    int   cyc;
    bit   seen;
    seen = 0;
    cyc  = 0;
    for (int i = 1; i <= 200 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (get_done(sel)) begin
        seen = 1;
        cyc  = i;
      end
    end
    e = sb.pop_front();
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s timeout: no done, want lat %0d",
               nm, e.lat);
    end else begin
      if (cyc !== e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d want %0d",
                 nm, cyc, e.lat);
      end
      n_chk++;
      if (get_out(sel) !== e.v) begin
        n_fail++;
        $display("FAIL %s out: got %h want %h",
                 nm, get_out(sel), e.v);
      end
      n_chk++;
      if (get_busy(sel) !== 1'b0) begin
        n_fail++;
        $display("FAIL %s busy at done: got %b want 0",
                 nm, get_busy(sel));
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(1, 1'b0, 2'b00, 0, 32'h0);
    drive(4, 1'b0, 2'b00, 0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if ({b1.busy, b1.done, b4.busy, b4.done} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset flags: got %b want 0000",
               {b1.busy, b1.done, b4.busy, b4.done});
    end
    n_chk++;
    if (b1.out !== 32'h0 || b4.out !== 32'h0) begin
      n_fail++;
      $display("FAIL reset out: got %h/%h want 0",
               b1.out, b4.out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_sll;
    issue(1, 2'b00, 2, 32'h0000_0001);
    wait_done(1, "sll_1");
    @(posedge clk);
    #1;
    n_chk++;
    if (b1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL done_pulse: got %b want 0", b1.done);
    end
    n_chk++;
    if (b1.out !== 32'h0000_0004) begin
      n_fail++;
      $display("FAIL out_hold: got %h want 00000004", b1.out);
    end
    issue(1, 2'b00, 2, 32'h1234_5678);
    wait_done(1, "sll_legacy");
    n_chk++;
    if (b1.out !== 32'h48D1_59E0) begin
      n_fail++;
      $display("FAIL sll_legacy const: got %h want 48d159e0",
               b1.out);
    end
  endtask

  task automatic test_right;
    issue(1, 2'b10, 31, 32'h8000_0000);
    wait_done(1, "sra_31");
    issue(1, 2'b01, 31, 32'h8000_0000);
    wait_done(1, "srl_31");
  endtask

  task automatic test_rol_step4;
    issue(4, 2'b11, 4, 32'h8000_0001);
    wait_done(4, "rol_4");
    issue(4, 2'b11, 6, 32'h8000_0001);
    wait_done(4, "rol_6_partial");
    issue(4, 2'b10, 31, 32'h8000_0000);
    wait_done(4, "sra_31_s4");
  endtask

  task automatic test_back_to_back;
    exp_t e;
    issue(1, 2'b10, 0, 32'hDEAD_BEEF);
    wait_done(1, "zero_shamt");
    // start held during the done cycle
    drive(1, 1'b1, 2'b00, 2, 32'h0000_0001);
    e.v   = model(2'b00, 2, 32'h0000_0001);
    e.lat = lat_of(2, 1);
    sb.push_back(e);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 2'b00, 0, 32'h0);
    n_chk++;
    if (b1.busy !== 1'b1 || b1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b accept: busy %b done %b want 1 0",
               b1.busy, b1.done);
    end
    wait_done(1, "b2b_second");
  endtask

  task automatic test_busy_ignore;
    exp_t e;
    int   pulses;
    int   first;
    logic [31:0] got;
    issue(1, 2'b00, 10, 32'h0000_0003);
    repeat (3) @(posedge clk);
    #1;
    drive(1, 1'b1, 2'b01, 1, 32'hFFFF_0000);
    @(posedge clk);
    #1;
    drive(1, 1'b0, 2'b00, 0, 32'h0);
    pulses = 0;
    first  = 0;
    got    = 32'h0;
    for (int i = 5; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (b1.done) begin
        pulses++;
        if (first == 0) begin
          first = i;
          got   = b1.out;
        end
      end
    end
    e = sb.pop_front();
    n_chk++;
    if (pulses !== 1) begin
      n_fail++;
      $display("FAIL busy_ignore pulses: got %0d want 1", pulses);
    end
    n_chk++;
    if (got !== e.v || first !== e.lat) begin
      n_fail++;
      $display("FAIL busy_ignore result: got %h@%0d want %h@%0d",
               got, first, e.v, e.lat);
    end
  endtask

  task automatic test_random;
    logic [1:0] m;
    int sh;
    logic [31:0] x;
    for (int k = 0; k < 6; k++) begin
      m  = 2'($urandom_range(0, 3));
      sh = $urandom_range(0, 31);
      x  = $urandom;
      issue(4, m, sh, x);
      wait_done(4, "rand_s4");
      issue(1, m, sh, x);
      wait_done(1, "rand_s1");
    end
  endtask

  task automatic test_reset_mid;
    int pulses;
    exp_t e;
    issue(1, 2'b11, 20, 32'hA5A5_0F0F);
    e = sb.pop_front();
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset flags: busy %b done %b want 0 0",
               b1.busy, b1.done);
    end
    n_chk++;
    if (b1.out !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_reset out: got %h want 0", b1.out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (b1.done || b1.busy) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $display("FAIL mid_reset after: got %0d active cycles want 0",
               pulses);
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    test_reset();
    test_sll();
    test_right();
    test_rol_step4();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
